// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM state encoding and default operand geometry.
package alu_pkg;

  localparam int unsigned DefaultWidth = 32;
  localparam int unsigned DefaultLanes = 2;

  // 2'd3 is unused; the FSM recovers from it to StIdle.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/and_chunk_reduce.sv
// Combinational AND-reduction of one LANES-wide operand chunk.
module and_chunk_reduce #(
  parameter int unsigned LANES = 2
) (
  input  logic [LANES-1:0] a_chunk,
  input  logic [LANES-1:0] b_chunk,
  output logic             chunk_ok
);

  assign chunk_ok = &(a_chunk & b_chunk);

endmodule

// File: rtl/and_reduce_serial.sv
// Bit-serial y = &(a & b), LANES bit-pairs per cycle, LSB chunk first,
// stopping at the first chunk that contains a zero pair.
module and_reduce_serial
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned LANES = DefaultLanes,
  localparam int unsigned N    = WIDTH / LANES,
  localparam int unsigned CW   = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             y,
  output logic [CW-1:0]    cycles
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             y_q, y_d;
  logic [CW-1:0]    cycles_q, cycles_d;
  logic             chunk_ok;

  and_chunk_reduce #(
    .LANES (LANES)
  ) u_chunk (
    .a_chunk  (a_q[LANES*idx_q +: LANES]),
    .b_chunk  (b_q[LANES*idx_q +: LANES]),
    .chunk_ok (chunk_ok)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    y_d      = y_q;
    cycles_d = cycles_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (!chunk_ok) begin
          y_d      = 1'b0;
          cycles_d = CW'(idx_q) + CW'(1);
          state_d  = StDone;
        end else if (idx_q == IW'(N - 1)) begin
          // Last chunk checked before any increment, so idx never wraps.
          y_d      = 1'b1;
          cycles_d = CW'(N);
          state_d  = StDone;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      y_q      <= 1'b0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      y_q      <= y_d;
      cycles_q <= cycles_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign y         = y_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_and_reduce_serial.sv
// Randomized self-checking bench for and_reduce_serial against a behavioural model.
module tb_and_reduce_serial;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned LANES = 2;
  localparam int unsigned N     = WIDTH / LANES;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic             y;
  logic [4:0]       cycles;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  and_reduce_serial #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .cycles    (cycles)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Result is decided by the lowest zero bit of a&b: its chunk is the last one evaluated.
  task automatic model(input logic [31:0] ma, input logic [31:0] mb,
                       output logic exp_y, output int exp_c);
    logic [31:0] ab;
    int pos;
    ab = ma & mb;
    if (ab == 32'hFFFF_FFFF) begin
      exp_y = 1'b1;
      exp_c = N;
    end else begin
      pos = 0;
      while (ab[pos]) pos++;
      exp_y = 1'b0;
      exp_c = pos / LANES + 1;
    end
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 64) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_txn(input logic [31:0] ta, input logic [31:0] tb_op, input int hold);
    logic exp_y;
    int exp_c;
    int n;
    logic [31:0] exp_vec;
    model(ta, tb_op, exp_y, exp_c);
    @(negedge clk);
    in_valid = 1'b1;
    a = ta;
    b = tb_op;
    check_eq("in_ready_idle", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    wait_out(n);
    check_eq("latency", n, exp_c);
    check_eq("y", y, exp_y);
    check_eq("cycles", cycles, exp_c);
    exp_vec = {24'd0, 1'b1, 1'b0, exp_y, exp_c[4:0]};
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      @(negedge clk);
      check_eq("hold", {24'd0, out_valid, in_ready, y, cycles}, exp_vec);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("release", {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    int n;
    int seen;
    logic [31:0] ra, rb;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_y", y, 0);
    check_eq("rst_cycles", cycles, 0);

    // Directed cases
    run_txn(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_txn(32'hFFFF_FFFE, 32'hFFFF_FFFF, 0);
    run_txn(32'h7FFF_FFFF, 32'hFFFF_FFFF, 0);
    run_txn(32'hFFFF_FFFF, 32'hFFFF_FEFF, 0);
    run_txn(32'h0, 32'h0, 10);

    // Reset during RUN cycle 8 must discard the in-flight result
    @(negedge clk);
    in_valid = 1'b1;
    a = 32'hFFFF_FFFF;
    b = 32'hFFFF_FFFF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_rst_in_ready", in_ready, 1);
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_y", y, 0);
    check_eq("mid_rst_cycles", cycles, 0);
    seen = 0;
    out_ready = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    check_eq("no_stale_result", seen, 0);

    // Back-to-back with in_valid held and operands changed during RUN
    @(negedge clk);
    in_valid = 1'b1;
    a = 32'hFFFF_FFFF;
    b = 32'hFFFF_FFFF;
    @(negedge clk);
    a = 32'h0000_0003;
    b = 32'h0000_0001;
    seen = 0;
    n = 0;
    while (!out_valid && n < 64) begin
      if (in_ready) seen++;
      @(negedge clk);
      n++;
    end
    check_eq("b2b_in_ready_run", seen, 0);
    check_eq("b2b_latency1", n, 16);
    check_eq("b2b_y1", y, 1);
    check_eq("b2b_cycles1", cycles, 16);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("b2b_idle", {30'd0, in_ready, out_valid}, 32'd2);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("b2b_accept2", in_ready, 0);
    wait_out(n);
    check_eq("b2b_latency2", n, 1);
    check_eq("b2b_y2", y, 0);
    check_eq("b2b_cycles2", cycles, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Random pairs: all-ones, mostly-ones with sparse zeros, or fully random
    for (int t = 0; t < 1000; t++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          ra = 32'hFFFF_FFFF;
          rb = 32'hFFFF_FFFF;
        end
        3, 4, 5, 6: begin
          ra = ~(32'd1 << $urandom_range(0, 31));
          rb = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : ~(32'd1 << $urandom_range(0, 31));
        end
        default: begin
          ra = $urandom;
          rb = $urandom;
        end
      endcase
      run_txn(ra, rb, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
